// File: rtl/playback_sequencer_if.sv
// -----------------------------------------------------------------------------
// playback_sequencer_if
//   Bundles the SRAM read port and the sample stream toward the DAC serializer.
//
//   o_sram_addr    : SRAM word address
//   o_sram_oe      : SRAM read enable
//   i_sram_dq      : SRAM read data
//   o_sample       : sample offered to the DAC serializer
//   o_sample_valid : sample offered
//   i_sample_ready : serializer accepts (transfer = valid & ready)
//
//   master : the sequencer side
//   slave  : the SRAM / DAC side
// -----------------------------------------------------------------------------
interface playback_sequencer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] o_sram_addr;
    logic              o_sram_oe;
    logic [DATA_W-1:0] i_sram_dq;
    logic [DATA_W-1:0] o_sample;
    logic              o_sample_valid;
    logic              i_sample_ready;

    modport master (
        output o_sram_addr, o_sram_oe, o_sample, o_sample_valid,
        input  i_sram_dq, i_sample_ready
    );

    modport slave (
        input  o_sram_addr, o_sram_oe, o_sample, o_sample_valid,
        output i_sram_dq, i_sample_ready
    );
endinterface

// File: rtl/playback_sequencer.sv
// -----------------------------------------------------------------------------
// playback_sequencer
//   Walks SRAM addresses 0..i_end_addr, fetches one sample per address and
//   offers it to the DAC serializer over valid/ready. Supports play, pause,
//   stop, fast-forward (address skip by speed) and slow-motion (each sample
//   offered speed times), speed 1..8.
//
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : start from idle/done, or resume from pause
//   i_pause        : pause request
//   i_stop         : abort, back to idle
//   i_fast         : 1 = skip addresses, 0 = repeat samples
//   i_speed        : ratio; 0 acts as 1, values above 8 act as 8
//   i_end_addr     : last address played (inclusive)
//   bus            : SRAM read port and sample stream (master side)
//   o_busy         : fetching, offering or paused
//   o_done         : end of material reached
//   o_addr         : current play address
// -----------------------------------------------------------------------------
module playback_sequencer #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int SRAM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    playback_sequencer_if.master bus,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_OFFER = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] LAT_CNT = 2'(SRAM_LAT);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [2:0]        rep_cnt_q, rep_cnt_d;
    logic [3:0]        speed_q, speed_d;
    logic              fast_q, fast_d;
    logic [1:0]        wait_q, wait_d;
    logic              pause_pend_q, pause_pend_d;  // pause seen during a fetch
    logic              held_q, held_d;              // fetched sample still owed to the DAC

    logic [3:0]        spd_eff;
    logic [ADDR_W:0]   step;
    logic [ADDR_W:0]   next_addr;
    logic              past_end;
    logic              xfer;
    logic              repeat_more;

    always_comb begin
        spd_eff = i_speed;
        if (i_speed == 4'd0) begin
            spd_eff = 4'd1;
        end else if (i_speed > 4'd8) begin
            spd_eff = 4'd8;
        end
    end

    // Carry bit is kept so an advance past the top of the address space
    // compares as beyond the end instead of wrapping to 0.
    assign step        = fast_q ? (ADDR_W+1)'(speed_q) : (ADDR_W+1)'(1);
    assign next_addr   = {1'b0, addr_q} + step;
    assign past_end    = next_addr > {1'b0, i_end_addr};
    assign xfer        = (state_q == S_OFFER) && bus.i_sample_ready;
    assign repeat_more = !fast_q && ({1'b0, rep_cnt_q} < (speed_q - 4'd1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sample_d     = sample_q;
        rep_cnt_d    = rep_cnt_q;
        speed_d      = speed_q;
        fast_d       = fast_q;
        wait_d       = wait_q;
        pause_pend_d = pause_pend_q;
        held_d       = held_q;

        if (i_stop) begin
            state_d      = S_IDLE;
            addr_d       = '0;
            rep_cnt_d    = '0;
            wait_d       = '0;
            pause_pend_d = 1'b0;
            held_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start && !i_pause) begin
                        state_d      = S_FETCH;
                        addr_d       = '0;
                        speed_d      = spd_eff;
                        fast_d       = i_fast;
                        rep_cnt_d    = '0;
                        wait_d       = '0;
                        pause_pend_d = 1'b0;
                        held_d       = 1'b0;
                    end
                end
                S_FETCH: begin
                    if (i_pause) begin
                        pause_pend_d = 1'b1;
                    end
                    // Address has been on the bus SRAM_LAT cycles: data is valid now.
                    if (wait_q == LAT_CNT) begin
                        sample_d     = bus.i_sram_dq;
                        wait_d       = '0;
                        held_d       = 1'b1;
                        pause_pend_d = 1'b0;
                        state_d      = (pause_pend_q || i_pause) ? S_PAUSE : S_OFFER;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                S_OFFER: begin
                    if (xfer) begin
                        if (repeat_more) begin
                            rep_cnt_d = rep_cnt_q + 3'd1;
                            if (i_pause) begin
                                state_d = S_PAUSE;
                            end
                        end else begin
                            rep_cnt_d = '0;
                            held_d    = 1'b0;
                            if (past_end) begin
                                state_d = S_DONE;
                            end else begin
                                addr_d  = next_addr[ADDR_W-1:0];
                                speed_d = spd_eff;
                                fast_d  = i_fast;
                                state_d = i_pause ? S_PAUSE : S_FETCH;
                            end
                        end
                    end else if (i_pause) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (i_start && !i_pause) begin
                        state_d = held_q ? S_OFFER : S_FETCH;
                        wait_d  = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            sample_q     <= '0;
            rep_cnt_q    <= '0;
            speed_q      <= 4'd1;
            fast_q       <= 1'b0;
            wait_q       <= '0;
            pause_pend_q <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sample_q     <= sample_d;
            rep_cnt_q    <= rep_cnt_d;
            speed_q      <= speed_d;
            fast_q       <= fast_d;
            wait_q       <= wait_d;
            pause_pend_q <= pause_pend_d;
            held_q       <= held_d;
        end
    end

    // All outputs decode registered state, so reset clears them at once.
    assign bus.o_sram_addr    = addr_q;
    assign bus.o_sram_oe      = (state_q == S_FETCH);
    assign bus.o_sample       = sample_q;
    assign bus.o_sample_valid = (state_q == S_OFFER);
    assign o_busy             = (state_q == S_FETCH) || (state_q == S_OFFER) || (state_q == S_PAUSE);
    assign o_done             = (state_q == S_DONE);
    assign o_addr             = addr_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_playback_sequencer
//   Drives playback_sequencer with directed and randomized play sessions.
//   The expected transfer list for a session is derived from the play rules
//   (addresses 0..end stepping by speed in fast mode, each sample repeated
//   speed times in slow mode); pauses and backpressure must not change it.
//   Address width is reduced so a full-range fast sweep stays short.
// -----------------------------------------------------------------------------
module tb_playback_sequencer;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, pause, stop, fast;
    logic [3:0]    speed;
    logic [AW-1:0] end_addr;
    logic          busy, done;
    logic [AW-1:0] o_addr;

    int n_chk = 0;
    int n_err = 0;
    int nxfer = 0;

    logic [DW-1:0] exp_d[$];
    logic [AW-1:0] exp_a[$];

    logic [AW-1:0] a_pipe  [LAT];
    logic          oe_pipe [LAT];

    playback_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    playback_sequencer #(.ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_fast     (fast),
        .i_speed    (speed),
        .i_end_addr (end_addr),
        .bus        (bus),
        .o_busy     (busy),
        .o_done     (done),
        .o_addr     (o_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = (a < AW'(15)) ? 16'((32'(a) + 32'd1) * 32'h1111) : (16'(a) ^ 16'hA5A5);
        return v;
    endfunction

    // SRAM: data appears LAT cycles after the address is driven with oe high;
    // before that the bus carries a poison value.
    always @(posedge clk) begin
        a_pipe[0]  <= bus.o_sram_addr;
        oe_pipe[0] <= bus.o_sram_oe;
        for (int i = 1; i < LAT; i++) begin
            a_pipe[i]  <= a_pipe[i-1];
            oe_pipe[i] <= oe_pipe[i-1];
        end
    end
    assign bus.i_sram_dq = oe_pipe[LAT-1] ? mem_val(a_pipe[LAT-1]) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every transfer (valid & ready at the coming edge) is matched against the model.
    always @(negedge clk) begin
        #2;
        if (rst_n && bus.o_sample_valid && bus.i_sample_ready) begin
            nxfer++;
            chk("xfer_expected", 32'(exp_d.size() != 0), 1);
            if (exp_d.size() != 0) begin
                chk("xfer_data", bus.o_sample, exp_d.pop_front());
                chk("xfer_addr", o_addr, exp_a.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic build_exp(input int e, input int spd, input bit f);
        int s, st, rep;
        exp_d.delete();
        exp_a.delete();
        s   = (spd == 0) ? 1 : (spd > 8) ? 8 : spd;
        st  = f ? s : 1;
        rep = f ? 1 : s;
        for (int a = 0; a <= e; a += st) begin
            for (int r = 0; r < rep; r++) begin
                exp_d.push_back(mem_val(AW'(a)));
                exp_a.push_back(AW'(a));
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.o_sample_valid && n < 50) begin
            tick();
            n++;
        end
        chk(tag, bus.o_sample_valid, 1);
    endtask

    task automatic session_end(input string tag, input int n0, input int want_n);
        bus.i_sample_ready = 1'b0;
        pause = 1'b0;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_left"}, exp_d.size(), 0);
        if (want_n >= 0) chk({tag, "_count"}, nxfer - n0, want_n);
        tick();
        chk({tag, "_no_valid"}, bus.o_sample_valid, 0);
    endtask

    // One play session with random ready and pause pulses; resumes when paused.
    task automatic run(input string tag, input int e, input int spd, input bit f,
                       input int p_ready, input int p_pause, input int want_n);
        int n0, cyc;
        build_exp(e, spd, f);
        n0       = nxfer;
        end_addr = AW'(e);
        speed    = 4'(spd);
        fast     = f;
        pause    = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 4000) begin
            bus.i_sample_ready = ($urandom_range(99) < p_ready);
            pause = ($urandom_range(99) < p_pause);
            start = !pause && busy && !bus.o_sample_valid && !bus.o_sram_oe
                    && ($urandom_range(3) == 0);
            tick();
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        session_end(tag, n0, want_n);
    endtask

    initial begin
        int n, n0, bad;
        logic [DW-1:0] s0;

        rst_n = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0; fast = 1'b0;
        speed = 4'd1; end_addr = '0;
        bus.i_sample_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", bus.o_sample_valid, 0);
        chk("rst_oe", bus.o_sram_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_sram_addr", bus.o_sram_addr, 0);
        chk("rst_sample", bus.o_sample, 0);
        rst_n = 1'b1;
        tick();

        // Fetch latency: SRAM_LAT+1 cycles from entering fetch to valid.
        build_exp(0, 1, 0);
        end_addr = '0; speed = 4'd1; fast = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("fetch_oe", bus.o_sram_oe, 1);
        chk("fetch_busy", busy, 1);
        n = 0;
        while (!bus.o_sample_valid && n < 10) begin tick(); n++; end
        chk("fetch_latency", n, LAT + 1);
        bus.i_sample_ready = 1'b1;
        wait_done("single_done", 20);
        session_end("single", nxfer - 1, -1);

        run("normal", 3, 1, 0, 100, 0, 4);
        run("slow3", 1, 3, 0, 100, 0, 6);
        run("fast4", 10, 4, 1, 100, 0, 3);
        run("speed0", 2, 0, 0, 100, 0, 3);
        run("speed15_fast", 20, 15, 1, 100, 0, 3);
        run("speed15_slow", 1, 15, 0, 100, 0, 16);
        run("end0_slow", 0, 5, 0, 100, 0, 5);
        run("overflow", (1 << AW) - 1, 8, 1, 80, 0, (1 << AW) / 8);

        // Speed is latched at start and re-latched only at the address advance.
        build_exp(0, 2, 0);
        exp_d.push_back(mem_val(AW'(1)));
        exp_a.push_back(AW'(1));
        n0 = nxfer;
        end_addr = AW'(1); speed = 4'd2; fast = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        speed = 4'd1;
        bus.i_sample_ready = 1'b1;
        wait_done("relatch_done", 100);
        session_end("relatch", n0, 3);

        // Backpressure then pause / resume.
        build_exp(3, 1, 0);
        n0 = nxfer;
        end_addr = AW'(3); speed = 4'd1; fast = 1'b0;
        bus.i_sample_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("bp_valid");
        s0  = bus.o_sample;
        bad = 0;
        repeat (20) begin
            tick();
            if (!bus.o_sample_valid || bus.o_sample !== s0) bad++;
        end
        chk("bp_hold", bad, 0);
        chk("bp_sample", s0, mem_val(AW'(0)));
        pause = 1'b1; tick(); pause = 1'b0;
        chk("pause_valid_drop", bus.o_sample_valid, 0);
        chk("pause_busy", busy, 1);
        repeat (3) tick();
        chk("pause_oe", bus.o_sram_oe, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_valid", bus.o_sample_valid, 1);
        chk("resume_sample", bus.o_sample, s0);
        chk("resume_addr", o_addr, 0);
        bus.i_sample_ready = 1'b1;
        wait_done("pause_done", 100);
        session_end("pause", n0, 4);

        // Stop on the second wait cycle of the fetch of address 1.
        build_exp(0, 1, 0);
        end_addr = AW'(3); speed = 4'd1; fast = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("stop_first_valid");
        bus.i_sample_ready = 1'b1; tick(); bus.i_sample_ready = 1'b0;
        chk("stop_fetch_addr", o_addr, 1);
        chk("stop_fetch_oe", bus.o_sram_oe, 1);
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_oe", bus.o_sram_oe, 0);
        chk("stop_addr", o_addr, 0);
        chk("stop_busy", busy, 0);
        chk("stop_valid", bus.o_sample_valid, 0);
        n0 = nxfer;
        bus.i_sample_ready = 1'b1;
        repeat (6) tick();
        chk("stop_no_xfer", nxfer - n0, 0);
        chk("stop_idle_done", done, 0);
        run("after_stop", 3, 1, 0, 100, 0, 4);

        // Randomized sessions with backpressure and pauses.
        for (int k = 0; k < 12; k++) begin
            run("rand", $urandom_range(12), $urandom_range(15), 1'($urandom_range(1)),
                $urandom_range(100, 50), $urandom_range(15), -1);
        end

        // Asynchronous reset while a sample is on offer.
        build_exp(3, 1, 0);
        end_addr = AW'(3); speed = 4'd1; fast = 1'b0;
        bus.i_sample_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("areset_valid_before");
        #1 rst_n = 1'b0;
        #1;
        chk("areset_valid", bus.o_sample_valid, 0);
        chk("areset_busy", busy, 0);
        chk("areset_sample", bus.o_sample, 0);
        chk("areset_addr", o_addr, 0);
        exp_d.delete();
        exp_a.delete();
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
Sequences audio playback from external SRAM into the DAC serializer. Walks SRAM addresses from 0 to a programmable end address and fetches one 16-bit sample per address. Offers each sample to the DAC side over a valid/ready handshake. Supports play, pause, stop, fast-forward (address skip) and slow-motion (sample repeat) at integer ratios 1..8.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, sample width
SRAM_LAT, 1, cycles from o_sram_addr valid to i_sram_dq valid (1..3)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start, or resume when paused (level sampled each cycle)
i_pause  in  1  pause request
i_stop  in  1  stop; abort and return to idle
i_fast  in  1  1 = fast mode (skip), 0 = slow/normal mode (repeat)
i_speed  in  4  ratio 1..8; 0 treated as 1; >8 clamped to 8
i_end_addr  in  ADDR_W  last address to play (inclusive)
o_sram_addr  out  ADDR_W  read address
o_sram_oe  out  1  read enable, high in S_FETCH
i_sram_dq  in  DATA_W  read data
o_sample  out  DATA_W  sample offered to DAC serializer
o_sample_valid  out  1  sample offered
i_sample_ready  in  1  DAC serializer accepts (transfer = valid & ready)
o_busy  out  1  high in S_FETCH, S_OFFER, S_PAUSE
o_done  out  1  high while in S_DONE
o_addr  out  ADDR_W  current play address (for display)

Behaviour:
- Reset: state S_IDLE. addr, o_sram_addr, o_sample, o_addr = 0. o_sram_oe, o_sample_valid, o_busy, o_done = 0. rep_cnt = 0. Latched speed = 1.
- Command priority: i_stop > i_pause > i_start.
- i_stop in any state: next cycle S_IDLE, addr = 0, valid = 0, oe = 0. A sample in flight is discarded.
- S_IDLE:
  - On i_start: addr = 0, latch speed/fast, rep_cnt = 0, go to S_FETCH.
- S_FETCH:
  - oe = 1, o_sram_addr = addr.
  - Wait counter runs SRAM_LAT cycles.
  - On expiry: capture i_sram_dq into o_sample, go to S_OFFER with valid = 1.
  - Total latency from entering S_FETCH to valid high is SRAM_LAT+1 cycles.
  - i_pause during S_FETCH: the fetch completes, then the block enters S_PAUSE instead of S_OFFER.
- S_OFFER:
  - o_sample_valid = 1. o_sample is held stable until transfer.
  - On transfer, in slow mode (i_fast = 0) with rep_cnt < speed-1: rep_cnt++, remain in S_OFFER, valid stays 1, same sample is re-offered.
  - On transfer, otherwise: rep_cnt = 0 and next = addr + step, where step = speed if fast, else 1. Next is computed at ADDR_W+1 bits.
    - If next > i_end_addr, or next overflows: go to S_DONE.
    - Else: addr = next, re-latch speed/fast, go to S_FETCH. valid drops the cycle after the transfer.
  - i_pause with no transfer in the same cycle: valid = 0 next cycle, go to S_PAUSE, sample and rep_cnt held.
  - i_pause in the same cycle as a transfer: the transfer completes and the address advances. The next state is S_PAUSE, and the fetch of the new address happens on resume.
- S_PAUSE:
  - valid = 0, oe = 0.
  - On i_start with i_pause low: go to S_OFFER if a sample is held and not yet transferred, else S_FETCH.
  - A held flag records which case applies.
- S_DONE:
  - o_done = 1, busy = 0, valid = 0.
  - i_start restarts from addr 0 via S_FETCH.
  - i_stop goes to S_IDLE.
- Speed/fast changes take effect only at the next address advance or at start. rep_cnt is never re-evaluated mid-sample.
- i_end_addr = 0: exactly one address is played; repeats still apply in slow mode.
- o_addr mirrors addr.
- Async reset asserted mid-operation: all outputs take their reset values immediately.

Test Plan:
- Normal play: end_addr = 3, speed = 1, fast = 0, SRAM[0..3] = 0x1111/0x2222/0x3333/0x4444, ready always 1 -> exactly 4 transfers in order, then o_done = 1, o_busy = 0.
- Slow x3: end_addr = 1, speed = 3, fast = 0 -> transfers 0x1111 x3 then 0x2222 x3 (6 total), then S_DONE.
- Fast x4: end_addr = 10, speed = 4, fast = 1 -> addresses 0, 4, 8 fetched, 3 transfers, then S_DONE (next = 12 > 10).
- Backpressure and pause: hold ready = 0 for 20 cycles -> valid stays 1 with o_sample constant. Pulse i_pause -> valid = 0 next cycle. i_start -> same sample re-offered and no address skipped.
- Stop mid-fetch with SRAM_LAT = 2: assert i_stop on the second wait cycle -> next cycle S_IDLE, oe = 0, o_addr = 0, no transfer. A subsequent i_start begins at addr 0.
- Edge cases:
  - speed = 0 behaves as 1; speed = 15 behaves as 8.
  - end_addr = 2^20-1 with fast x8 terminates on overflow without wrapping to 0.
  - Async reset asserted during S_OFFER -> valid = 0 immediately.
